ws2812_rx: RTL and testbench

- Decoder for the WS2812/NeoPixel single-wire protocol; the receive end of the stream our PMod NeoPixel firmware drives onto the pins.
- Samples one PMod input pin and measures each high-pulse width to recover bits.
- Assembles 24-bit GRB pixel words and flags frame ends (reset gaps) and timing errors.
- Optionally forwards the stream after consuming the first pixel, as a real LED does. Used for loopback checking of the transmitter and for chaining.

---
 rtl/ws2812_pkg.sv | 20 ++
 rtl/ws2812_din_sync.sv | 21 ++
 rtl/ws2812_rx.sv | 150 +++++++++++++++
 tb/tb_ws2812_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 single-wire transmitter and receiver.
// Timing defaults assume a 12 MHz system clock.
package ws2812_pkg;

  typedef enum logic [1:0] {
    WAIT_GAP,
    IDLE,
    HIGH,
    LOW
  } ws2812_state_t;

  localparam int unsigned BITS_PER_PIXEL = 24;
  localparam int unsigned BIT_CNT_W      = $clog2(BITS_PER_PIXEL);

  localparam int unsigned T_MIN_HIGH_12M = 2;
  localparam int unsigned T_THRESH_12M   = 7;
  localparam int unsigned T_MAX_HIGH_12M = 14;
  localparam int unsigned T_RESET_12M    = 600;

endpackage

// File: rtl/ws2812_din_sync.sv
// Two-flop synchroniser for the asynchronous WS2812 data pin.
module ws2812_din_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic din_s
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      din_s <= 1'b0;
    end else begin
      meta  <= din;
      din_s <= meta;
    end
  end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: decodes high-pulse widths into GRB pixels, reports frame
// gaps and timing errors, and optionally re-forwards the stream after pixel 0.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned T_MIN_HIGH = T_MIN_HIGH_12M,
  parameter int unsigned T_THRESH   = T_THRESH_12M,
  parameter int unsigned T_MAX_HIGH = T_MAX_HIGH_12M,
  parameter int unsigned T_RESET    = T_RESET_12M,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned FORWARD    = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      DIN,
  output logic [BITS_PER_PIXEL-1:0] PIX_DATA,
  output logic                      PIX_VALID,
  output logic [IDX_W-1:0]          PIX_INDEX,
  output logic                      FRAME_END,
  output logic                      BIT_ERR,
  output logic                      BUSY,
  output logic                      DOUT
);

  localparam int unsigned CNT_W = $clog2(T_RESET + 1);

  localparam logic [CNT_W-1:0]     C_MIN    = CNT_W'(T_MIN_HIGH);
  localparam logic [CNT_W-1:0]     C_THRESH = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0]     C_MAX    = CNT_W'(T_MAX_HIGH);
  localparam logic [CNT_W-1:0]     C_RESET  = CNT_W'(T_RESET);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITS_PER_PIXEL - 1);

  ws2812_state_t             state;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_inc;
  logic [BIT_CNT_W-1:0]      bit_cnt;
  logic [BITS_PER_PIXEL-2:0] shreg;
  logic [IDX_W-1:0]          idx;
  logic                      fwd_en;
  logic                      din_s;
  logic                      bit_val;

  ws2812_din_sync u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (DIN),
    .din_s (din_s)
  );

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign bit_val = (cnt >= C_THRESH);

  // Pulse-width FSM; the strobes are only ever set on mutually exclusive paths.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= WAIT_GAP;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      idx       <= '0;
      fwd_en    <= 1'b0;
      PIX_DATA  <= '0;
      PIX_VALID <= 1'b0;
      PIX_INDEX <= '0;
      FRAME_END <= 1'b0;
      BIT_ERR   <= 1'b0;
      BUSY      <= 1'b0;
      DOUT      <= 1'b0;
    end else begin
      PIX_VALID <= 1'b0;
      FRAME_END <= 1'b0;
      BIT_ERR   <= 1'b0;
      DOUT      <= (FORWARD != 0) && fwd_en && din_s;

      case (state)
        WAIT_GAP: begin
          if (din_s) begin
            cnt <= '0;
          end else if (cnt_inc >= C_RESET) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        IDLE: begin
          if (din_s) begin
            cnt   <= CNT_W'(1);
            state <= HIGH;
            BUSY  <= 1'b1;
          end
        end

        HIGH: begin
          if (din_s ? (cnt_inc >= C_MAX) : (cnt < C_MIN)) begin
            BIT_ERR <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            idx     <= '0;
            fwd_en  <= 1'b0;
            state   <= WAIT_GAP;
            BUSY    <= 1'b0;
          end else if (din_s) begin
            cnt <= cnt_inc;
          end else begin
            cnt   <= CNT_W'(1);
            state <= LOW;
            if (bit_cnt == LAST_BIT) begin
              PIX_DATA  <= {shreg, bit_val};
              PIX_VALID <= 1'b1;
              PIX_INDEX <= idx;
              idx       <= (idx == '1) ? idx : idx + IDX_W'(1);
              fwd_en    <= 1'b1;
              bit_cnt   <= '0;
            end else begin
              shreg   <= {shreg[BITS_PER_PIXEL-3:0], bit_val};
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end

        LOW: begin
          if (din_s) begin
            cnt   <= CNT_W'(1);
            state <= HIGH;
          end else if (cnt_inc >= C_RESET) begin
            // A gap mid-pixel is a truncated pixel, not a frame end.
            if (bit_cnt == '0) FRAME_END <= 1'b1;
            else               BIT_ERR   <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            idx     <= '0;
            fwd_en  <= 1'b0;
            state   <= IDLE;
            BUSY    <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state <= WAIT_GAP;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: stimulus pushes expected strobes, a negedge
// monitor pops and compares them, and also checks DOUT gating/mirroring.
module tb_ws2812_rx;

  localparam int unsigned IDX_W = 8;

  typedef enum logic [1:0] {EV_PIX, EV_FE, EV_ERR, EV_BAD} ev_t;
  typedef struct {
    ev_t         kind;
    logic [23:0] data;
    logic [7:0]  idx;
    int          cyc;
  } exp_t;

  exp_t sbq[$];

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             din = 1'b0;
  logic [23:0]      pix_data;
  logic             pix_valid;
  logic [IDX_W-1:0] pix_index;
  logic             frame_end;
  logic             bit_err;
  logic             busy;
  logic             dout;

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         last_fall = 0;
  int         dmode = 0;
  logic [2:0] hist = '0;
  ev_t        mon_k;
  exp_t       mon_e;

  ws2812_rx #(
    .T_MIN_HIGH (2),
    .T_THRESH   (7),
    .T_MAX_HIGH (14),
    .T_RESET    (600),
    .IDX_W      (IDX_W),
    .FORWARD    (1)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .DIN       (din),
    .PIX_DATA  (pix_data),
    .PIX_VALID (pix_valid),
    .PIX_INDEX (pix_index),
    .FRAME_END (frame_end),
    .BIT_ERR   (bit_err),
    .BUSY      (busy),
    .DOUT      (dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    hist <= {hist[1:0], din};
  end

  // Monitor: DOUT window checks plus scoreboard pop on any strobe.
  always @(negedge clk) begin
    if (dmode == 1) begin
      checks++;
      if (dout !== 1'b0) begin
        errors++;
        $display("FAIL dout_blocked cyc=%0d got=%b want=0", cyc, dout);
      end
    end else if (dmode == 2) begin
      checks++;
      if (dout !== hist[2]) begin
        errors++;
        $display("FAIL dout_mirror cyc=%0d got=%b want=%b", cyc, dout, hist[2]);
      end
    end
    if (pix_valid || frame_end || bit_err) begin
      if ((32'(pix_valid) + 32'(frame_end) + 32'(bit_err)) > 1) mon_k = EV_BAD;
      else if (pix_valid) mon_k = EV_PIX;
      else if (frame_end) mon_k = EV_FE;
      else                mon_k = EV_ERR;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe cyc=%0d got=%s data=%06h idx=%0d want=none",
                 cyc, mon_k.name(), pix_data, pix_index);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_k != mon_e.kind ||
            (mon_k == EV_PIX && (pix_data !== mon_e.data || pix_index !== mon_e.idx)) ||
            (mon_e.cyc != 0 && mon_e.cyc != cyc)) begin
          errors++;
          $display("FAIL strobe got=%s data=%06h idx=%0d cyc=%0d want=%s data=%06h idx=%0d cyc=%0d",
                   mon_k.name(), pix_data, pix_index, cyc,
                   mon_e.kind.name(), mon_e.data, mon_e.idx, mon_e.cyc);
        end
      end
    end
  end

  function automatic void push(input ev_t k, input logic [23:0] d, input logic [7:0] i,
                               input int c);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.idx  = i;
    e.cyc  = c;
    sbq.push_back(e);
  endfunction

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    logic [37:0] v;
    v = {pix_data, pix_index, pix_valid, frame_end, bit_err, busy, dout};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s got=%010h want=0", name, v);
    end
  endtask

  // Hold DIN at v for n cycles; always returns 1 time unit after a posedge.
  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [23:0] px, input int nb, input int h0, input int h1,
                           input int l0, input int l1, input bit exp_px, input int idx);
    logic b;
    for (int i = 23; i >= 24 - nb; i--) begin
      b = px[i];
      drive(1'b1, b ? h1 : h0);
      if (i == 0 && exp_px) push(EV_PIX, px, 8'(idx), cyc + 3);
      last_fall = cyc;
      drive(1'b0, b ? l1 : l0);
    end
  endtask

  task automatic std_pixel(input logic [23:0] px, input int idx, input bit exp_px);
    send_bits(px, 24, 5, 10, 10, 5, exp_px, idx);
  endtask

  task automatic gap_fe(input int n);
    push(EV_FE, '0, '0, last_fall + 602);
    drive(1'b0, n);
  endtask

  initial begin
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
    drive(1'b0, 605);

    // 1: single pixel after the start-up gap
    std_pixel(24'h123456, 0, 1);
    check_bit("busy_in_low", busy, 1'b1);
    gap_fe(700);
    check_bit("busy_idle", busy, 1'b0);

    // 2: three-pixel frame, then a new frame restarts at index 0
    std_pixel(24'hFF0000, 0, 1);
    std_pixel(24'h00FF00, 1, 1);
    std_pixel(24'h0000FF, 2, 1);
    gap_fe(700);
    std_pixel(24'hABCDEF, 0, 1);
    gap_fe(700);

    // 3: width boundaries (6/7 around threshold, 2 and 13 at the limits)
    send_bits(24'hA5C3E1, 24, 6, 7, 8, 8, 1, 0);
    send_bits(24'h3C96F0, 24, 2, 13, 8, 8, 1, 1);
    gap_fe(700);
    send_bits(24'h555555, 10, 5, 10, 10, 5, 0, 0);
    push(EV_ERR, '0, '0, cyc + 4);
    drive(1'b1, 1);
    drive(1'b0, 10);
    std_pixel(24'hDEAD00, 0, 0);
    drive(1'b0, 605);
    std_pixel(24'h0F0F0F, 0, 1);
    gap_fe(700);

    // 4: stuck-high line mid-pixel
    send_bits(24'h9A0000, 8, 5, 10, 10, 5, 0, 0);
    push(EV_ERR, '0, '0, cyc + 16);
    drive(1'b1, 20);
    drive(1'b0, 10);
    send_bits(24'hF0F0F0, 8, 5, 10, 10, 5, 0, 0);
    drive(1'b0, 605);
    std_pixel(24'h112233, 0, 1);
    gap_fe(700);

    // 5: truncated pixel ended by a gap
    send_bits(24'hC3A000, 12, 5, 10, 10, 5, 0, 0);
    push(EV_ERR, '0, '0, last_fall + 602);
    drive(1'b0, 700);
    std_pixel(24'h654321, 0, 1);
    gap_fe(700);

    // 6: forwarding, then async reset mid-pixel
    dmode = 1;
    std_pixel(24'h102030, 0, 1);
    dmode = 2;
    std_pixel(24'h405060, 1, 1);
    dmode = 0;
    gap_fe(700);
    dmode = 1;
    std_pixel(24'h7E8192, 0, 1);
    dmode = 2;
    send_bits(24'hB5B5B5, 5, 5, 10, 10, 5, 0, 0);
    din = 1'b1;
    repeat (4) @(posedge clk);
    dmode = 0;
    check_bit("busy_mid_pixel", busy, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 620);
    check_zero("after_reset_gap");

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
